// File: rtl/gpio_in_conditioner_pkg.sv
// Shared helpers for the GPIO input conditioner; all tunables remain module parameters.
package gpio_in_conditioner_pkg;

  // Debounce counter width: must hold values up to DB_CYCLES.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// Pad-side and core-side signal bundle of the GPIO input conditioner.
interface gpio_in_conditioner_if #(
  parameter int unsigned GPIO_WIDTH = 8
);
  logic [GPIO_WIDTH-1:0] pad_i;
  logic [GPIO_WIDTH-1:0] rise_en_i;
  logic [GPIO_WIDTH-1:0] fall_en_i;
  logic [GPIO_WIDTH-1:0] clr_i;
  logic [GPIO_WIDTH-1:0] gpio_q;
  logic [GPIO_WIDTH-1:0] rise_o;
  logic [GPIO_WIDTH-1:0] fall_o;
  logic [GPIO_WIDTH-1:0] pend_o;
  logic                  irq_o;

  modport master (
    output pad_i, rise_en_i, fall_en_i, clr_i,
    input  gpio_q, rise_o, fall_o, pend_o, irq_o
  );

  modport slave (
    input  pad_i, rise_en_i, fall_en_i, clr_i,
    output gpio_q, rise_o, fall_o, pend_o, irq_o
  );
endinterface

// File: rtl/gpio_in_conditioner_debounce.sv
// Single-bit synchroniser, debouncer and registered edge detector.
module gpio_debounce_bit
  import gpio_in_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 1024,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned    CW      = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   stable_q;
  logic [CW-1:0]          cnt_q;

  assign sync  = sync_q[SYNC_STAGES-1];
  assign level = stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  // Any cycle where sync agrees with the stable level restarts the count,
  // so the accept compare alone bounds the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_q <= sync;
        cnt_q    <= '0;
        rise     <= sync;
        fall     <= ~sync;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_in_conditioner.sv
// Per-bit pad conditioning with sticky edge-pending flags and a combined interrupt.
module gpio_in_conditioner
  import gpio_in_conditioner_pkg::*;
#(
  parameter int unsigned           GPIO_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter int unsigned           DB_CYCLES   = 1024,
  parameter logic [GPIO_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gpio_in_conditioner_if.slave   bus
);

  logic [GPIO_WIDTH-1:0] level;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] fall;
  logic [GPIO_WIDTH-1:0] pend_q;
  logic                  irq_q;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .RESET_VAL   (RESET_VAL[i])
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .pad   (bus.pad_i[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // Set term is OR-ed after the clear so a coincident new edge wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~bus.clr_i)
              | (rise & bus.rise_en_i)
              | (fall & bus.fall_en_i);
      irq_q  <= |pend_q;
    end
  end

  assign bus.gpio_q = level;
  assign bus.rise_o = rise;
  assign bus.fall_o = fall;
  assign bus.pend_o = pend_q;
  assign bus.irq_o  = irq_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner with SYNC_STAGES=2, DB_CYCLES=4.
module tb_gpio_in_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  gpio_in_conditioner_if #(.GPIO_WIDTH(8)) bus ();

  gpio_in_conditioner #(
    .GPIO_WIDTH  (8),
    .SYNC_STAGES (2),
    .DB_CYCLES   (4),
    .RESET_VAL   (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.pad_i     = 8'h00;
    bus.rise_en_i = 8'h00;
    bus.fall_en_i = 8'h00;
    bus.clr_i     = 8'h00;

    // 1: reset and idle
    tick(2);
    chk("reset_state", {bus.gpio_q, bus.rise_o, bus.fall_o, bus.pend_o, 7'd0, bus.irq_o}, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle", {bus.gpio_q, bus.rise_o, bus.fall_o, bus.pend_o, 7'd0, bus.irq_o}, '0);
    end

    // 2: rise on bit 0, pad captured at E1
    bus.rise_en_i = 8'h01;
    bus.pad_i     = 8'h01;
    tick(5);
    chk("rise_e1p4_q", 40'(bus.gpio_q), 40'h00);
    tick(1);
    chk("rise_e1p5_q", 40'(bus.gpio_q), 40'h01);
    chk("rise_e1p5_rise", 40'(bus.rise_o), 40'h01);
    chk("rise_e1p5_pend", 40'(bus.pend_o), 40'h00);
    tick(1);
    chk("rise_e1p6_rise", 40'(bus.rise_o), 40'h00);
    chk("rise_e1p6_pend", 40'(bus.pend_o), 40'h01);
    chk("rise_e1p6_irq", 40'(bus.irq_o), 40'h0);
    tick(1);
    chk("rise_e1p7_irq", 40'(bus.irq_o), 40'h1);

    // 3a: 3-cycle glitch on bit 3 is filtered
    bus.pad_i = 8'h09;
    tick(3);
    bus.pad_i = 8'h01;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch3", {bus.gpio_q, bus.rise_o, bus.fall_o}, {8'h01, 8'h00, 8'h00});
    end

    // 3b: 4-cycle pulse is accepted; low then held for fall
    bus.pad_i = 8'h09;
    tick(4);
    bus.pad_i = 8'h01;
    tick(1);
    chk("p4_e5_q", 40'(bus.gpio_q), 40'h01);
    tick(1);
    chk("p4_e6_q", 40'(bus.gpio_q), 40'h09);
    chk("p4_e6_rise", 40'(bus.rise_o), 40'h08);
    tick(1);
    chk("p4_e7_rise", 40'(bus.rise_o), 40'h00);
    tick(2);
    chk("p4_e9_q", {bus.gpio_q, bus.fall_o}, {8'h09, 8'h00});
    tick(1);
    chk("p4_e10_q", 40'(bus.gpio_q), 40'h01);
    chk("p4_e10_fall", 40'(bus.fall_o), 40'h08);
    tick(1);
    chk("p4_e11_fall", 40'(bus.fall_o), 40'h00);
    chk("p4_e11_pend", 40'(bus.pend_o), 40'h01);

    // 4: clear coincident with a new enabled rise; set wins
    bus.pad_i = 8'h00;
    tick(8);
    chk("clr_pre_q", {bus.gpio_q, bus.pend_o}, {8'h00, 8'h01});
    bus.pad_i = 8'h01;
    tick(6);
    chk("clr_rise", 40'(bus.rise_o), 40'h01);
    bus.clr_i = 8'h01;
    tick(1);
    chk("clr_set_wins", 40'(bus.pend_o), 40'h01);
    tick(1);
    chk("clr_alone", 40'(bus.pend_o), 40'h00);
    chk("clr_irq_lag", 40'(bus.irq_o), 40'h1);
    bus.clr_i = 8'h00;
    tick(1);
    chk("clr_irq_low", 40'(bus.irq_o), 40'h0);

    // 5: all bits fall together
    bus.rise_en_i = 8'h00;
    bus.fall_en_i = 8'hFF;
    bus.pad_i     = 8'hFF;
    tick(8);
    chk("all_high", {bus.gpio_q, bus.pend_o}, {8'hFF, 8'h00});
    bus.pad_i = 8'h00;
    tick(6);
    chk("all_fall", {bus.gpio_q, bus.fall_o}, {8'h00, 8'hFF});
    tick(1);
    chk("all_pend", {bus.fall_o, bus.pend_o}, {8'h00, 8'hFF});
    tick(1);
    chk("all_irq", 40'(bus.irq_o), 40'h1);
    bus.fall_en_i = 8'h00;
    tick(1);
    chk("en_drop_keeps_pend", 40'(bus.pend_o), 40'hFF);

    // 6: async reset with bit 5 half-counted
    bus.pad_i = 8'h01;
    tick(8);
    chk("pre_rst_q", {bus.gpio_q, bus.pend_o}, {8'h01, 8'hFF});
    bus.pad_i = 8'h21;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {bus.gpio_q, bus.rise_o, bus.fall_o, bus.pend_o, 7'd0, bus.irq_o}, '0);
    #2;
    rst_n = 1'b1;
    tick(5);
    chk("rst_recount_e4", {bus.gpio_q, bus.rise_o}, {8'h00, 8'h00});
    tick(1);
    chk("rst_recount_e5", {bus.gpio_q, bus.rise_o}, {8'h21, 8'h21});
    tick(1);
    chk("rst_recount_pend", {bus.rise_o, bus.pend_o}, {8'h00, 8'h00});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gpio_in_conditioner.md
# gpio_in_conditioner

Input conditioning stage that sits directly upstream of the `gpio_i` port of the AHB-lite GPIO peripheral. It takes raw, asynchronous pad inputs and produces the following per bit:
- a synchronised, debounced level;
- single-cycle rise and fall event pulses;
- sticky edge-pending flags that combine into one interrupt line.

Every bit is processed independently. The clean level vector drives the GPIO core's input. The interrupt goes to the system interrupt controller.

## Interface

Parameters:
- `GPIO_WIDTH`, default 8: number of input bits.
- `SYNC_STAGES`, default 2: synchroniser flop count. Legal range is 2 or more.
- `DB_CYCLES`, default 1024: consecutive stable cycles required to accept a new level. Legal range is 1 or more.
- `RESET_VAL`, default all zeros: `GPIO_WIDTH` bits. Reset value of the synchroniser and debounced level.

Ports:
- `clk` in, 1: the single clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `pad_i` in, `GPIO_WIDTH`: raw asynchronous pad inputs.
- `rise_en_i` in, `GPIO_WIDTH`: per-bit enable for setting pending on a rising edge.
- `fall_en_i` in, `GPIO_WIDTH`: per-bit enable for setting pending on a falling edge.
- `clr_i` in, `GPIO_WIDTH`: per-bit pending clear, sampled every cycle.
- `gpio_q` out, `GPIO_WIDTH`: debounced level. Connects to the GPIO core `gpio_i`.
- `rise_o` out, `GPIO_WIDTH`: one-cycle pulse when `gpio_q[n]` goes 0 to 1.
- `fall_o` out, `GPIO_WIDTH`: one-cycle pulse when `gpio_q[n]` goes 1 to 0.
- `pend_o` out, `GPIO_WIDTH`: sticky pending flags.
- `irq_o` out, 1: registered OR of all `pend_o` bits.

## Operation

Per-bit datapath: synchroniser, then debouncer, then edge detect, then pending flag.

Synchroniser:
- `SYNC_STAGES` flops in series.
- Output is `sync[n]`.
- No logic is placed between the stages.

Debouncer:
- State per bit: stable level `s[n]` (equal to `gpio_q[n]`) and counter `cnt[n]`.
- Counter width is `$clog2(DB_CYCLES+1)`.
- If `sync[n] == s[n]`: `cnt[n]` is set to 0.
- Else if `cnt[n] == DB_CYCLES-1`: `s[n]` is set to `sync[n]`, `cnt[n]` is set to 0, and the matching edge pulse is registered.
- Otherwise: `cnt[n]` increments by 1.
- Any cycle in which `sync` returns to `s` restarts the count, so glitches shorter than `DB_CYCLES` never propagate.
- The counter never wraps. It saturates logically because the accept condition resets it.

Edge pulses:
- `rise_o[n]` and `fall_o[n]` are registered on the same edge as the `gpio_q` update.
- Each pulse lasts exactly 1 cycle.
- `rise_o` and `fall_o` are never asserted together for one bit.

Pending flags:
- Set when `(rise_o[n] & rise_en_i[n]) | (fall_o[n] & fall_en_i[n])`, evaluated on the registered pulse. The flag therefore sets 1 cycle after the pulse.
- Cleared when `clr_i[n]` is high.
- Simultaneous set and clear: set wins.
- Enables are level-sampled. Changing an enable never clears an existing pending flag.

Interrupt:
- `irq_o` is a registered `|pend`, one cycle after `pend_o` changes.

## Timing

Reset values:
- Synchroniser flops, `s`, and `gpio_q` reset to `RESET_VAL`.
- `cnt` resets to 0.
- `rise_o`, `fall_o`, `pend_o`, and `irq_o` reset to 0.
- Because `s` starts equal to the synchroniser contents, no edge is reported on reset release when the pads equal `RESET_VAL`.

Latency (a pad change first captured at edge E1, then held stable):
- `gpio_q`, `rise_o`, and `fall_o` update at edge E1 + `SYNC_STAGES` + `DB_CYCLES` − 1.
- `pend_o` updates 1 cycle later.
- `irq_o` updates 2 cycles later.

Pulse length: with `DB_CYCLES`=1, a single-cycle glitch that survives the synchroniser is accepted. This is legal, and it is the minimum filter setting.

Reset mid-operation:
- Asynchronous assertion forces all state to reset values immediately.
- Partially counted changes are lost.
- Pending flags are lost.

## Structure

- A shared package holds no types; all constants are module parameters.
- One sub-module, `gpio_debounce_bit`, contains the synchroniser, debouncer and edge registers for a single bit. It is instantiated `GPIO_WIDTH` times in a generate loop.
- Pending flags and `irq_o` live in the top module.

## Test plan

Parameters for all scenarios: `GPIO_WIDTH`=8, `SYNC_STAGES`=2, `DB_CYCLES`=4, `RESET_VAL`=0.

1. Reset with `pad_i`=0x00, then release, idle 20 cycles.
   - `gpio_q`=0x00, `rise_o`=`fall_o`=0x00, `pend_o`=0x00, `irq_o`=0 throughout.
2. `rise_en_i`=0x01, `pad_i[0]` goes 0 to 1 before edge E1 and is held.
   - `gpio_q[0]`=1 and `rise_o`=0x01 for one cycle at E1+5.
   - `pend_o`=0x01 at E1+6.
   - `irq_o`=1 at E1+7.
3. `pad_i[3]` high for 3 cycles, then low.
   - `gpio_q[3]` stays 0.
   - No pulse occurs and `cnt` returns to 0.
   - Repeat with 4 cycles: `rise_o[3]` pulses once, then `fall_o[3]` pulses after the low is held for 4 more cycles.
4. `pend_o[0]`=1, with `clr_i[0]` asserted in the same cycle that a new enabled `rise_o[0]` is registered.
   - `pend_o[0]` stays 1 because set wins.
   - `clr_i[0]` alone next cycle gives `pend_o[0]`=0, and `irq_o`=0 one cycle later.
5. `fall_en_i`=0xFF, `pad_i` goes 0xFF to 0x00 after `gpio_q` has settled at 0xFF.
   - `fall_o`=0xFF in a single cycle.
   - `pend_o`=0xFF the next cycle.
6. `pad_i[5]` has changed and `cnt[5]`=2 when `rst_n` is pulled low asynchronously mid-cycle.
   - Outputs go to reset values before the next clock edge.
   - After release, the count restarts from 0.
